// File: rtl/sobel_px_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_px_streamer_pkg
// Brief    : Shared pixel width, frame size defaults and streamer state type.
// Revision : 1.0 - initial release
// ============================================================================
package sobel_px_streamer_pkg;

  localparam int PIXEL_WIDTH_OUT = 8;
  localparam int IMG_W_DEFAULT   = 16;
  localparam int IMG_H_DEFAULT   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_FIRST = 3'd2,
    ST_NEXT  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } strm_state_t;

  // Bits needed to hold the values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_px_streamer_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : sobel_addr_gen
// Brief    : Strip/row/column counters and row-base accumulator for frame reads.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_addr_gen
  import sobel_px_streamer_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEFAULT,
  parameter int IMG_H  = IMG_H_DEFAULT,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              frame_clr_i,
  input  logic              strip_next_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_col_o,
  output logic              win_done_o,
  output logic              last_row_o,
  output logic              last_strip_o
);

  localparam int c_X_W = cnt_width(IMG_W - 3);
  localparam int c_Y_W = cnt_width(IMG_H - 1);

  localparam logic [c_X_W-1:0]  c_X_LAST   = c_X_W'(IMG_W - 3);
  localparam logic [c_Y_W-1:0]  c_Y_LAST   = c_Y_W'(IMG_H - 1);
  localparam logic [c_Y_W-1:0]  c_Y_WIN    = c_Y_W'(2);
  localparam logic [ADDR_W-1:0] c_ROW_STEP = ADDR_W'(IMG_W);

  logic [c_X_W-1:0]  r_x;
  logic [c_Y_W-1:0]  r_y;
  logic [1:0]        r_col;
  logic [ADDR_W-1:0] r_row_base;

  assign last_col_o   = (r_col == 2'd2);
  assign last_row_o   = (r_y == c_Y_LAST);
  assign win_done_o   = (r_y == c_Y_WIN);
  assign last_strip_o = (r_x == c_X_LAST);

  // Counters hold on the final read of a strip so the row base never passes the frame end.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_x        <= '0;
      r_y        <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (frame_clr_i) begin
      r_x        <= '0;
      r_y        <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (strip_next_i) begin
      r_x        <= r_x + c_X_W'(1);
      r_y        <= '0;
      r_col      <= '0;
      r_row_base <= '0;
    end else if (step_i && !(last_col_o && last_row_o)) begin
      if (last_col_o) begin
        r_col      <= '0;
        r_y        <= r_y + c_Y_W'(1);
        r_row_base <= r_row_base + c_ROW_STEP;
      end else begin
        r_col <= r_col + 2'd1;
      end
    end
  end

  assign addr_o = r_row_base + ADDR_W'(r_x) + ADDR_W'(r_col);

endmodule
`default_nettype wire

// File: rtl/sobel_px_streamer.sv
`default_nettype none
// ============================================================================
// Module   : sobel_px_streamer
// Brief    : Reads a stored frame and streams 3-column strips to the Sobel window assembler.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_px_streamer
  import sobel_px_streamer_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEFAULT,
  parameter int IMG_H     = IMG_H_DEFAULT,
  parameter int ADDR_W    = $clog2(IMG_W * IMG_H),
  parameter int PX_GAP    = 0,
  parameter int STRIP_GAP = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       frame_start_i,
  output logic                       mem_rd_en_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic [PIXEL_WIDTH_OUT-1:0] mem_data_i,
  output logic                       start_sobel_o,
  output logic                       px_rdy_o,
  output logic [PIXEL_WIDTH_OUT-1:0] px_o,
  output logic                       busy_o,
  output logic                       done_o
);

  generate
    if (IMG_W < 3) begin : g_chk_img_w
      $error("sobel_px_streamer: IMG_W must be >= 3");
    end
    if (IMG_H < 3) begin : g_chk_img_h
      $error("sobel_px_streamer: IMG_H must be >= 3");
    end
    if (STRIP_GAP < 1) begin : g_chk_strip_gap
      $error("sobel_px_streamer: STRIP_GAP must be >= 1");
    end
  endgenerate

  localparam int c_PXG_W = cnt_width(PX_GAP);
  localparam int c_SG_W  = cnt_width(STRIP_GAP - 1);

  localparam logic [c_PXG_W-1:0] c_PX_GAP_LD = c_PXG_W'(PX_GAP);
  localparam logic [c_SG_W-1:0]  c_SG_LAST   = c_SG_W'(STRIP_GAP - 1);

  strm_state_t r_state;
  strm_state_t w_state_nxt;

  logic                       w_accept;
  logic                       w_rd_en;
  logic                       w_start;
  logic                       w_done;
  logic                       w_clr;
  logic                       w_strip_next;
  logic [ADDR_W-1:0]          w_addr;
  logic                       w_last_col;
  logic                       w_win_done;
  logic                       w_last_row;
  logic                       w_last_strip;
  logic [c_PXG_W-1:0]         r_px_gap;
  logic [c_SG_W-1:0]          r_sg_cnt;
  logic                       r_rd_d1;
  logic                       r_px_rdy;
  logic [PIXEL_WIDTH_OUT-1:0] r_px;
  logic                       r_start_d1;
  logic                       r_start;
  logic                       r_done_d1;
  logic                       r_done;
  logic                       r_busy;

  sobel_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .frame_clr_i  (w_clr),
    .strip_next_i (w_strip_next),
    .step_i       (w_rd_en),
    .addr_o       (w_addr),
    .last_col_o   (w_last_col),
    .win_done_o   (w_win_done),
    .last_row_o   (w_last_row),
    .last_strip_o (w_last_strip)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_rd_en      = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_clr        = 1'b0;
    w_strip_next = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // busy_o still covers the two-cycle output pipeline after the FSM returns here.
        if (frame_start_i && !r_busy) begin
          w_accept    = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        w_start     = 1'b1;
        w_state_nxt = ST_FIRST;
      end
      ST_FIRST, ST_NEXT: begin
        w_start = 1'b1;
        if (r_px_gap == '0) begin
          w_rd_en = 1'b1;
          if (w_last_col && w_last_row) begin
            w_state_nxt = ST_GAP;
          end else if (w_last_col && w_win_done) begin
            w_state_nxt = ST_NEXT;
          end
        end
      end
      ST_GAP: begin
        if (r_sg_cnt == c_SG_LAST) begin
          if (w_last_strip) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_strip_next = 1'b1;
            w_state_nxt  = ST_ARM;
          end
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_px_gap <= '0;
    end else if (w_rd_en) begin
      r_px_gap <= c_PX_GAP_LD;
    end else if ((r_state != ST_FIRST) && (r_state != ST_NEXT)) begin
      r_px_gap <= '0;
    end else if (r_px_gap != '0) begin
      r_px_gap <= r_px_gap - c_PXG_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sg_cnt <= '0;
    end else if (r_state == ST_GAP) begin
      r_sg_cnt <= r_sg_cnt + c_SG_W'(1);
    end else begin
      r_sg_cnt <= '0;
    end
  end

  // Framing and done travel through the same two stages as the read data, keeping them aligned to px_rdy_o.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rd_d1    <= 1'b0;
      r_px_rdy   <= 1'b0;
      r_px       <= '0;
      r_start_d1 <= 1'b0;
      r_start    <= 1'b0;
      r_done_d1  <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rd_d1    <= w_rd_en;
      r_px_rdy   <= r_rd_d1;
      r_start_d1 <= w_start;
      r_start    <= r_start_d1;
      r_done_d1  <= w_done;
      r_done     <= r_done_d1;
      if (r_rd_d1) begin
        r_px <= mem_data_i;
      end
      if (w_accept) begin
        r_busy <= 1'b1;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign mem_rd_en_o   = w_rd_en;
  assign mem_addr_o    = w_rd_en ? w_addr : '0;
  assign start_sobel_o = r_start;
  assign px_rdy_o      = r_px_rdy;
  assign px_o          = r_px;
  assign busy_o        = r_busy;
  assign done_o        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sobel_px_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_px_streamer
// Brief    : Directed self-checking bench for the Sobel pixel streamer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_px_streamer;
  import sobel_px_streamer_pkg::*;

  localparam int PW = PIXEL_WIDTH_OUT;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Instance A: 4x4, PX_GAP=0. Instance G: 4x4, PX_GAP=2. Instance S: 3x6 constant image.
  logic fs_a, rd_a, st_a, rdy_a, busy_a, done_a;
  logic [3:0] addr_a;
  logic [PW-1:0] data_a, px_a;
  logic fs_g, rd_g, st_g, rdy_g, busy_g, done_g;
  logic [3:0] addr_g;
  logic [PW-1:0] data_g, px_g;
  logic fs_s, rd_s, st_s, rdy_s, busy_s, done_s;
  logic [4:0] addr_s;
  logic [PW-1:0] data_s, px_s;

  sobel_px_streamer #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .PX_GAP(0), .STRIP_GAP(2)) u_dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .frame_start_i(fs_a), .mem_rd_en_o(rd_a),
    .mem_addr_o(addr_a), .mem_data_i(data_a), .start_sobel_o(st_a), .px_rdy_o(rdy_a),
    .px_o(px_a), .busy_o(busy_a), .done_o(done_a));

  sobel_px_streamer #(.IMG_W(4), .IMG_H(4), .ADDR_W(4), .PX_GAP(2), .STRIP_GAP(2)) u_dut_g (
    .clk_i(clk_i), .reset_i(reset_i), .frame_start_i(fs_g), .mem_rd_en_o(rd_g),
    .mem_addr_o(addr_g), .mem_data_i(data_g), .start_sobel_o(st_g), .px_rdy_o(rdy_g),
    .px_o(px_g), .busy_o(busy_g), .done_o(done_g));

  sobel_px_streamer #(.IMG_W(3), .IMG_H(6), .ADDR_W(5), .PX_GAP(0), .STRIP_GAP(2)) u_dut_s (
    .clk_i(clk_i), .reset_i(reset_i), .frame_start_i(fs_s), .mem_rd_en_o(rd_s),
    .mem_addr_o(addr_s), .mem_data_i(data_s), .start_sobel_o(st_s), .px_rdy_o(rdy_s),
    .px_o(px_s), .busy_o(busy_s), .done_o(done_s));

  // Synchronous RAM models: RAM[a]=a for the 4x4 frames, 0x55 everywhere for the 3x6 frame.
  always @(posedge clk_i) if (rd_a) data_a <= PW'(addr_a);
  always @(posedge clk_i) if (rd_g) data_g <= PW'(addr_g);
  always @(posedge clk_i) if (rd_s) data_s <= 8'h55;

  int px_a_q[$], pc_a_q[$], rise_a_q[$], fall_a_q[$];
  int px_g_q[$], pc_g_q[$], rise_g_q[$];
  int px_s_q[$];
  int done_a_n = 0, done_g_n = 0, done_s_n = 0, rd_a_n = 0;
  logic st_a_prev = 1'b0, st_g_prev = 1'b0;

  always @(negedge clk_i) begin
    if (rdy_a) begin px_a_q.push_back(int'(px_a)); pc_a_q.push_back(cyc); end
    if (st_a && !st_a_prev) rise_a_q.push_back(cyc);
    if (!st_a && st_a_prev) fall_a_q.push_back(cyc);
    st_a_prev <= st_a;
    done_a_n  <= done_a_n + (done_a ? 1 : 0);
    rd_a_n    <= rd_a_n + (rd_a ? 1 : 0);
  end

  always @(negedge clk_i) begin
    if (rdy_g) begin px_g_q.push_back(int'(px_g)); pc_g_q.push_back(cyc); end
    if (st_g && !st_g_prev) rise_g_q.push_back(cyc);
    st_g_prev <= st_g;
    done_g_n  <= done_g_n + (done_g ? 1 : 0);
  end

  always @(negedge clk_i) begin
    if (rdy_s) px_s_q.push_back(int'(px_s));
    done_s_n <= done_s_n + (done_s ? 1 : 0);
  end

  int exp_px[24];

  function automatic int get_done(input int sel);
    case (sel)
      0:       return done_a_n;
      1:       return done_g_n;
      default: return done_s_n;
    endcase
  endfunction

  task automatic wait_done(input int sel, input int budget, input string name);
    int base;
    int i;
    base = get_done(sel);
    i = 0;
    while (get_done(sel) == base && i < budget) begin
      @(posedge clk_i); #1;
      i++;
    end
    tests_run++;
    if (get_done(sel) == base) begin
      tests_failed++;
      $display("FAIL %s_timeout: done_o not seen within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    int base_rd;
    reset_i = 1'b1; fs_a = 1'b0; fs_g = 1'b0; fs_s = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b1;
    #1;
    tests_run++;
    if ({rd_a, addr_a, st_a, rdy_a, px_a, busy_a, done_a} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required 0",
               {rd_a, addr_a, st_a, rdy_a, px_a, busy_a, done_a});
    end
    @(posedge clk_i); #1 reset_i = 1'b0;
    base_rd = rd_a_n;
    repeat (10) @(posedge clk_i);
    #1;
    tests_run++;
    if (rd_a_n != base_rd || rd_g !== 1'b0 || rd_s !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_no_read: got %0d reads required 0", rd_a_n - base_rd);
    end
  endtask

  task automatic test_stream();
    int base;
    px_a_q.delete(); pc_a_q.delete(); rise_a_q.delete(); fall_a_q.delete();
    base = done_a_n;
    fs_a = 1'b1; @(posedge clk_i); #1 fs_a = 1'b0;
    tests_run++;
    if (busy_a !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_set: got %b required 1", busy_a);
    end
    wait_done(0, 400, "stream");
    tests_run++;
    if (px_a_q.size() != 24) begin
      tests_failed++;
      $display("FAIL stream_count: got %0d required 24", px_a_q.size());
    end
    for (int i = 0; i < 24 && i < px_a_q.size(); i++) begin
      tests_run++;
      if (px_a_q[i] != exp_px[i]) begin
        tests_failed++;
        $display("FAIL stream_px[%0d]: got %0d required %0d", i, px_a_q[i], exp_px[i]);
      end
    end
    tests_run++;
    if (done_a_n - base != 1) begin
      tests_failed++;
      $display("FAIL stream_done_count: got %0d required 1", done_a_n - base);
    end
    tests_run++;
    if (busy_a !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_clear: got %b required 0", busy_a);
    end
  endtask

  task automatic test_framing();
    tests_run++;
    if (rise_a_q.size() != 2 || fall_a_q.size() != 2 || pc_a_q.size() != 24) begin
      tests_failed++;
      $display("FAIL framing_edges: got %0d rises %0d falls required 2 2",
               rise_a_q.size(), fall_a_q.size());
    end else begin
      tests_run++;
      if (rise_a_q[0] != pc_a_q[0] - 1) begin
        tests_failed++;
        $display("FAIL rise0_lead: got cycle %0d required %0d", rise_a_q[0], pc_a_q[0] - 1);
      end
      tests_run++;
      if (fall_a_q[0] != pc_a_q[11] + 1) begin
        tests_failed++;
        $display("FAIL fall0_after_12th: got cycle %0d required %0d", fall_a_q[0], pc_a_q[11] + 1);
      end
      tests_run++;
      if (rise_a_q[1] - fall_a_q[0] != 2) begin
        tests_failed++;
        $display("FAIL strip_gap_len: got %0d required 2", rise_a_q[1] - fall_a_q[0]);
      end
      tests_run++;
      if (rise_a_q[1] != pc_a_q[12] - 1) begin
        tests_failed++;
        $display("FAIL rise1_lead: got cycle %0d required %0d", rise_a_q[1], pc_a_q[12] - 1);
      end
      tests_run++;
      if (fall_a_q[1] != pc_a_q[23] + 1) begin
        tests_failed++;
        $display("FAIL fall1_after_24th: got cycle %0d required %0d", fall_a_q[1], pc_a_q[23] + 1);
      end
      tests_run++;
      if (pc_a_q[11] - pc_a_q[0] != 11) begin
        tests_failed++;
        $display("FAIL gap0_spacing: got span %0d required 11", pc_a_q[11] - pc_a_q[0]);
      end
    end
  endtask

  task automatic test_px_gap();
    int bad_val;
    int bad_gap;
    px_g_q.delete(); pc_g_q.delete(); rise_g_q.delete();
    fs_g = 1'b1; @(posedge clk_i); #1 fs_g = 1'b0;
    wait_done(1, 600, "px_gap");
    tests_run++;
    if (px_g_q.size() != 24) begin
      tests_failed++;
      $display("FAIL gap_count: got %0d required 24", px_g_q.size());
    end else begin
      bad_val = 0;
      bad_gap = 0;
      for (int i = 0; i < 24; i++) begin
        if (px_g_q[i] != exp_px[i]) bad_val++;
        if ((i % 12) != 0 && pc_g_q[i] - pc_g_q[i-1] != 3) bad_gap++;
      end
      tests_run++;
      if (bad_val != 0) begin
        tests_failed++;
        $display("FAIL gap_values: got %0d wrong pixels required 0", bad_val);
      end
      tests_run++;
      if (bad_gap != 0) begin
        tests_failed++;
        $display("FAIL gap_spacing: got %0d bad spacings required 0", bad_gap);
      end
      tests_run++;
      if (rise_g_q.size() < 1 || rise_g_q[0] != pc_g_q[0] - 1) begin
        tests_failed++;
        $display("FAIL gap_rise_lead: got %0d rises required first at cycle %0d",
                 rise_g_q.size(), pc_g_q[0] - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int i;
    int base_rd;
    int base_done;
    int bad_val;
    rise_a_q.delete();
    fs_a = 1'b1; @(posedge clk_i); #1 fs_a = 1'b0;
    i = 0;
    while (!(rise_a_q.size() >= 2 && rd_a === 1'b1 && addr_a === 4'd9) && i < 200) begin
      @(posedge clk_i); #1;
      i++;
    end
    tests_run++;
    if (i >= 200) begin
      tests_failed++;
      $display("FAIL midreset_reach_timeout: strip1 row2 read not seen in %0d cycles", i);
    end
    reset_i = 1'b1;
    #1;
    tests_run++;
    if ({rd_a, addr_a, st_a, rdy_a, px_a, busy_a, done_a} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %b required 0",
               {rd_a, addr_a, st_a, rdy_a, px_a, busy_a, done_a});
    end
    @(posedge clk_i); #1 reset_i = 1'b0;
    base_rd = rd_a_n;
    repeat (5) @(posedge clk_i);
    #1;
    tests_run++;
    if (rd_a_n != base_rd) begin
      tests_failed++;
      $display("FAIL midreset_idle: got %0d reads required 0", rd_a_n - base_rd);
    end
    px_a_q.delete(); pc_a_q.delete();
    base_done = done_a_n;
    fs_a = 1'b1; @(posedge clk_i); #1 fs_a = 1'b0;
    i = 0;
    while (rd_a !== 1'b1 && i < 10) begin
      @(posedge clk_i); #1;
      i++;
    end
    tests_run++;
    if (rd_a !== 1'b1 || addr_a !== 4'd0) begin
      tests_failed++;
      $display("FAIL restart_addr: got rd=%b addr=%0d required rd=1 addr=0", rd_a, addr_a);
    end
    repeat (4) @(posedge clk_i);
    #1 fs_a = 1'b1; @(posedge clk_i); #1 fs_a = 1'b0;
    wait_done(0, 400, "restart");
    tests_run++;
    if (px_a_q.size() != 24 || done_a_n - base_done != 1) begin
      tests_failed++;
      $display("FAIL busy_ignore: got %0d pulses %0d done required 24 1",
               px_a_q.size(), done_a_n - base_done);
    end else begin
      bad_val = 0;
      for (int k = 0; k < 24; k++) if (px_a_q[k] != exp_px[k]) bad_val++;
      tests_run++;
      if (bad_val != 0) begin
        tests_failed++;
        $display("FAIL restart_values: got %0d wrong pixels required 0", bad_val);
      end
    end
    base_rd = rd_a_n;
    repeat (10) @(posedge clk_i);
    #1;
    tests_run++;
    if (rd_a_n != base_rd) begin
      tests_failed++;
      $display("FAIL post_done_idle: got %0d reads required 0", rd_a_n - base_rd);
    end
  endtask

  task automatic test_end_to_end();
    int bad_val;
    int nres;
    int gx;
    int gy;
    int mag;
    px_s_q.delete();
    fs_s = 1'b1; @(posedge clk_i); #1 fs_s = 1'b0;
    wait_done(2, 300, "e2e");
    tests_run++;
    if (px_s_q.size() != 18) begin
      tests_failed++;
      $display("FAIL e2e_count: got %0d required 18", px_s_q.size());
    end
    bad_val = 0;
    foreach (px_s_q[k]) if (px_s_q[k] != 'h55) bad_val++;
    tests_run++;
    if (bad_val != 0) begin
      tests_failed++;
      $display("FAIL e2e_values: got %0d non-0x55 pixels required 0", bad_val);
    end
    nres = (px_s_q.size() / 3) - 2;
    tests_run++;
    if (nres != 4) begin
      tests_failed++;
      $display("FAIL e2e_results: got %0d Sobel results required 4", nres);
    end
    for (int r = 0; r < nres; r++) begin
      gx = (px_s_q[r*3+2] + 2*px_s_q[(r+1)*3+2] + px_s_q[(r+2)*3+2])
         - (px_s_q[r*3+0] + 2*px_s_q[(r+1)*3+0] + px_s_q[(r+2)*3+0]);
      gy = (px_s_q[(r+2)*3+0] + 2*px_s_q[(r+2)*3+1] + px_s_q[(r+2)*3+2])
         - (px_s_q[r*3+0] + 2*px_s_q[r*3+1] + px_s_q[r*3+2]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      tests_run++;
      if (mag != 0) begin
        tests_failed++;
        $display("FAIL e2e_sobel[%0d]: got %0d required 0", r, mag);
      end
    end
  endtask

  initial begin
    exp_px = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14,
               1, 2, 3, 5, 6, 7, 9, 10, 11, 13, 14, 15};
    test_reset();
    test_stream();
    test_framing();
    test_px_gap();
    test_reset_mid();
    test_end_to_end();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
